// File: rtl/seg7_digit_sequencer.sv
// rtl/seg7_digit_sequencer.sv - buffers hex digits and plays them back on one 7-segment display
// Optional continuous replay while run is held: define SEG7_SEQ_LOOP_EN.
module seg7_digit_sequencer #(
  parameter int DEPTH          = 8,
  parameter int DWELL_CYCLES   = 1000,
  parameter int GAP_CYCLES     = 100,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       run,
  input  logic       clear,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy,
  output logic       full
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int TMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef SEG7_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] timer;
  logic          run_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0:    seg_of = 7'h3F;
      4'h1:    seg_of = 7'h06;
      4'h2:    seg_of = 7'h5B;
      4'h3:    seg_of = 7'h4F;
      4'h4:    seg_of = 7'h66;
      4'h5:    seg_of = 7'h6D;
      4'h6:    seg_of = 7'h7D;
      4'h7:    seg_of = 7'h07;
      4'h8:    seg_of = 7'h7F;
      4'h9:    seg_of = 7'h6F;
      4'hA:    seg_of = 7'h77;
      4'hB:    seg_of = 7'h7C;
      4'hC:    seg_of = 7'h39;
      4'hD:    seg_of = 7'h5E;
      4'hE:    seg_of = 7'h79;
      default: seg_of = 7'h71;
    endcase
  endfunction

  logic          run_edge;
  logic          wr_ok;
  logic [CW-1:0] len_now;
  logic [3:0]    digit0;
  logic          is_last;
  logic [IW-1:0] nxt_idx;

  assign run_edge = run & ~run_q;
  assign wr_ok    = wr_en && (state == IDLE) && (count < CW'(DEPTH)) && !clear;
  // A write landing in the same cycle as the run edge is part of this playback.
  assign len_now  = count + CW'(wr_ok);
  assign digit0   = (count == '0) ? wr_data : mem[0];
  assign is_last  = (CW'(rd_idx) == count - CW'(1));
  assign nxt_idx  = is_last ? '0 : rd_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      rd_idx <= '0;
      timer  <= '0;
      run_q  <= 1'b0;
      seg_q  <= '0;
      dp_q   <= 1'b0;
    end else begin
      run_q <= run;
      if (clear) begin
        state  <= IDLE;
        count  <= '0;
        rd_idx <= '0;
        timer  <= '0;
        seg_q  <= '0;
        dp_q   <= 1'b0;
      end else begin
        if (wr_ok) count <= count + CW'(1);
        case (state)
          IDLE: begin
            if (run_edge && len_now != '0) begin
              state  <= SHOW;
              rd_idx <= '0;
              timer  <= DWELL_LOAD;
              seg_q  <= seg_of(digit0);
              dp_q   <= (len_now == CW'(1));
            end
          end
          SHOW: begin
            if (timer != '0) begin
              timer <= timer - TW'(1);
            end else if ((LOOP && !run) || (is_last && !LOOP)) begin
              state <= IDLE;
              seg_q <= '0;
              dp_q  <= 1'b0;
            end else if (GAP_CYCLES != 0) begin
              state <= GAP;
              timer <= GAP_LOAD;
              seg_q <= '0;
              dp_q  <= 1'b0;
            end else begin
              rd_idx <= nxt_idx;
              timer  <= DWELL_LOAD;
              seg_q  <= seg_of(mem[nxt_idx]);
              dp_q   <= (CW'(nxt_idx) == count - CW'(1));
            end
          end
          GAP: begin
            if (timer != '0) begin
              timer <= timer - TW'(1);
            end else if (LOOP && !run) begin
              state <= IDLE;
            end else begin
              state  <= SHOW;
              rd_idx <= nxt_idx;
              timer  <= DWELL_LOAD;
              seg_q  <= seg_of(mem[nxt_idx]);
              dp_q   <= (CW'(nxt_idx) == count - CW'(1));
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign seg  = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp   = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign busy = (state != IDLE);
  assign full = (count == CW'(DEPTH));

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// tb/tb_seg7_digit_sequencer.sv - scoreboard bench for seg7_digit_sequencer
// Looping scenario is exercised only when SEG7_SEQ_LOOP_EN is defined.
module tb_seg7_digit_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg, seg_n;
  logic       dp, dp_n, busy, busy_n, full, full_n;

  always #5 clk = ~clk;

  seg7_digit_sequencer #(.DEPTH(4), .DWELL_CYCLES(4), .GAP_CYCLES(2), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .run(run), .clear(clear),
    .seg(seg), .dp(dp), .busy(busy), .full(full));

  seg7_digit_sequencer #(.DEPTH(4), .DWELL_CYCLES(4), .GAP_CYCLES(2), .SEG_ACTIVE_LOW(1)) dut_n (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .run(run), .clear(clear),
    .seg(seg_n), .dp(dp_n), .busy(busy_n), .full(full_n));

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       full;
    string      tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Monitor: one expected sample per falling edge while the queue holds entries.
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (seg !== e.seg || dp !== e.dp || busy !== e.busy || full !== e.full) begin
        bad++;
        $display("FAIL %s: seg=%h dp=%b busy=%b full=%b, expected seg=%h dp=%b busy=%b full=%b",
                 e.tag, seg, dp, busy, full, e.seg, e.dp, e.busy, e.full);
      end
      total++;
      if (seg_n !== ~e.seg || dp_n !== ~e.dp || busy_n !== e.busy || full_n !== e.full) begin
        bad++;
        $display("FAIL %s/active_low: seg=%h dp=%b busy=%b full=%b, expected seg=%h dp=%b busy=%b full=%b",
                 e.tag, seg_n, dp_n, busy_n, full_n, ~e.seg, ~e.dp, e.busy, e.full);
      end
    end
  end

  task automatic push(input logic [6:0] s, input logic d, input logic b, input logic f,
                      input string t, input int n = 1);
    exp_t e;
    e.seg = s; e.dp = d; e.busy = b; e.full = f; e.tag = t;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Expected trace of one playback, starting with the sample just before the run edge.
  task automatic push_play(input logic [15:0] digs, input int n, input logic f, input string t);
    logic [3:0] d;
    push(7'h00, 1'b0, 1'b0, f, {t, "_pre"});
    for (int i = 0; i < n; i++) begin
      d = digs[4*i +: 4];
      push(tbl[d], (i == n - 1), 1'b1, f, $sformatf("%s_show%0d", t, i), 4);
      if (i < n - 1) push(7'h00, 1'b0, 1'b1, f, $sformatf("%s_gap%0d", t, i), 2);
    end
    push(7'h00, 1'b0, 1'b0, f, {t, "_post"}, 2);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d);
    cyc();
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push(7'h00, 1'b0, 1'b0, 1'b0, "reset");
    drain();

`ifdef SEG7_SEQ_LOOP_EN
    wr(4'h7);
    wr(4'hA);
    cyc();
    run = 1'b1;
    push(7'h00, 1'b0, 1'b0, 1'b0, "loop_pre");
    push(7'h07, 1'b0, 1'b1, 1'b0, "loop_7a", 4);
    push(7'h00, 1'b0, 1'b1, 1'b0, "loop_g1", 2);
    push(7'h77, 1'b1, 1'b1, 1'b0, "loop_a", 4);
    push(7'h00, 1'b0, 1'b1, 1'b0, "loop_g2", 2);
    push(7'h07, 1'b0, 1'b1, 1'b0, "loop_7b", 4);
    push(7'h00, 1'b0, 1'b0, 1'b0, "loop_stop", 2);
    repeat (14) cyc();
    run = 1'b0;
    drain();
`else
    // Basic three-digit playback.
    wr(4'h1); push(7'h00, 1'b0, 1'b0, 1'b0, "wr1");
    wr(4'h2); push(7'h00, 1'b0, 1'b0, 1'b0, "wr2");
    wr(4'h3); push(7'h00, 1'b0, 1'b0, 1'b0, "wr3");
    cyc();
    run = 1'b1;
    push_play(16'h0321, 3, 1'b0, "play123");
    cyc();
    run = 1'b0;
    drain();

    // Replay of the retained buffer with run held high stays one-shot.
    cyc();
    run = 1'b1;
    push_play(16'h0321, 3, 1'b0, "replay");
    drain();
    run = 1'b0;

    // Overfill: fifth write is dropped.
    do_clear();
    push(7'h00, 1'b0, 1'b0, 1'b0, "clr_idle");
    wr(4'h9); push(7'h00, 1'b0, 1'b0, 1'b0, "fill1");
    wr(4'hA); push(7'h00, 1'b0, 1'b0, 1'b0, "fill2");
    wr(4'hB); push(7'h00, 1'b0, 1'b0, 1'b0, "fill3");
    wr(4'hC); push(7'h00, 1'b0, 1'b0, 1'b1, "fill4_full");
    wr(4'hD); push(7'h00, 1'b0, 1'b0, 1'b1, "fill5_drop");
    cyc();
    run = 1'b1;
    push_play(16'hCBA9, 4, 1'b1, "playfull");
    cyc();
    run = 1'b0;
    drain();

    // Every table entry; odd digits use a write in the same cycle as the run edge.
    for (int d = 0; d < 16; d++) begin
      do_clear();
      cyc();
      if (d % 2 == 1) begin
        wr_en = 1'b1;
        wr_data = 4'(d);
        run = 1'b1;
        push_play(16'(d), 1, 1'b0, $sformatf("tbl%0d_same", d));
        cyc();
        wr_en = 1'b0;
        run = 1'b0;
      end else begin
        wr(4'(d));
        cyc();
        run = 1'b1;
        push_play(16'(d), 1, 1'b0, $sformatf("tbl%0d", d));
        cyc();
        run = 1'b0;
      end
      drain();
    end

    // Clear during the second digit.
    do_clear();
    wr(4'h1);
    wr(4'h2);
    wr(4'h3);
    cyc();
    run = 1'b1;
    push(7'h00, 1'b0, 1'b0, 1'b0, "clr_pre");
    push(7'h06, 1'b0, 1'b1, 1'b0, "clr_show0", 4);
    push(7'h00, 1'b0, 1'b1, 1'b0, "clr_gap0", 2);
    push(7'h5B, 1'b0, 1'b1, 1'b0, "clr_show1", 2);
    push(7'h00, 1'b0, 1'b0, 1'b0, "clr_abort", 2);
    cyc();
    run = 1'b0;
    repeat (7) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    drain();
    cyc();
    run = 1'b1;
    push(7'h00, 1'b0, 1'b0, 1'b0, "empty_run", 5);
    cyc();
    run = 1'b0;
    drain();

    // Asynchronous reset in the gap, then write lands in slot 0.
    wr(4'h1);
    wr(4'h2);
    cyc();
    run = 1'b1;
    push(7'h00, 1'b0, 1'b0, 1'b0, "rst_pre");
    push(7'h06, 1'b0, 1'b1, 1'b0, "rst_show0", 4);
    push(7'h00, 1'b0, 1'b1, 1'b0, "rst_gap");
    push(7'h00, 1'b0, 1'b0, 1'b0, "rst_async", 2);
    cyc();
    run = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drain();
    wr(4'h4);
    cyc();
    run = 1'b1;
    push_play(16'h0004, 1, 1'b0, "post_rst");
    cyc();
    run = 1'b0;
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_digit_sequencer.md
Name: seg7_digit_sequencer

Overview:
- Successor to the single-digit combinational hex-to-7-segment decoder.
- Buffers up to DEPTH 4-bit digits and plays them back one at a time on one 7-segment display.
- Each digit is held for DWELL_CYCLES, followed by a blank gap so that repeated digits stay distinguishable.
- Sits behind the 8-bit user IO: segment outputs drive io_out[6:0], dp drives io_out[7].

Parameters:
DEPTH, 8, number of digit slots in the buffer (>=2)
DWELL_CYCLES, 1000, clocks each digit is displayed (>=1)
GAP_CYCLES, 100, clocks of blank display between digits (0 = no gap state)
SEG_ACTIVE_LOW, 0, 1 inverts seg and dp for common-anode displays

Ports:
clk  input  1  system clock (io_in[0] at top level)
reset  input  1  asynchronous, active-high reset (io_in[1] at top level)
wr_en  input  1  append wr_data to buffer when accepted
wr_data  input  4  hex digit to append
run  input  1  level; rising edge starts playback
clear  input  1  synchronous pulse: empty buffer, abort playback
seg  output  7  segments, bit0=a .. bit6=g
dp  output  1  decimal point, marks last digit of sequence
busy  output  1  high while playback active
full  output  1  high when count == DEPTH

Behaviour:
- Reset (async, active-high):
  - count=0, rd_idx=0, state=IDLE, timers=0, run edge register=0.
  - Outputs: seg=blank, dp=off, busy=0, full=0.
  - Reset mid-playback aborts immediately; buffer contents are lost.
- Blank and off are all-zero, or all-one when SEG_ACTIVE_LOW=1.
- Buffer: DEPTH x 4 register array. count is $clog2(DEPTH+1) bits wide.
- Write rules:
  - A write is accepted when wr_en=1, state=IDLE, count<DEPTH and clear=0.
  - On acceptance: mem[count]<=wr_data; count<=count+1.
  - A write while full or busy is dropped silently; count is unchanged.
- Segment table (bit6..bit0 = g..a), hex:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- States: IDLE, SHOW, GAP.
  - IDLE -> SHOW:
    - Condition: rising edge of run (run=1 and run_q=0) with count>0.
    - Action: rd_idx<=0, timer<=DWELL_CYCLES-1.
    - A run edge with count=0 is ignored.
  - SHOW:
    - seg=table(mem[rd_idx]); dp on iff rd_idx==count-1.
    - Timer decrements each clock. At timer==0:
      - If not last digit: go to GAP (timer<=GAP_CYCLES-1), or straight to SHOW of rd_idx+1 when GAP_CYCLES==0.
      - If last digit: return to IDLE.
  - GAP:
    - seg=blank, dp=off.
    - At timer==0: rd_idx<=rd_idx+1, timer<=DWELL_CYCLES-1, go to SHOW.
- Latency: outputs are registered; the first digit appears on the clock after the registered run edge.
- Each digit is visible for exactly DWELL_CYCLES clocks; each gap is exactly GAP_CYCLES clocks.
- busy=1 in SHOW and GAP.
- clear has priority over everything: count<=0, rd_idx<=0, state<=IDLE, outputs blank on the next clock. Buffer contents need not be zeroed.
- Simultaneous wr_en and run edge in IDLE: the write is accepted first, and playback starts that cycle including the new digit (count+1 is used as the length).
- Buffer is retained after playback; run can replay it.
- Deasserting run during playback has no effect (one-shot).

Optional Feature:
- Macro: SEG7_SEQ_LOOP_EN.
- Defined:
  - After the last digit's SHOW, the block inserts a GAP (when GAP_CYCLES>0) and restarts at rd_idx=0 instead of returning to IDLE.
  - Looping continues while run=1.
  - Falling run, sampled at the end of any SHOW/GAP period, returns to IDLE.
  - clear still aborts immediately.
- Undefined: one-shot playback as above; run is edge-only.

Test Plan:
- DEPTH=4, DWELL=4, GAP=2. Write 1,2,3; pulse run.
  - Expect seg=06 for 4 clocks, blank 2, 5B for 4, blank 2, 4F for 4 with dp=1.
  - Then IDLE: busy=0, seg=00.
- Write 5 digits into DEPTH=4.
  - Expect full=1 after the 4th write; the 5th write is dropped; count=4.
- Write 0..F individually and play each.
  - Expect seg to match all 16 table entries.
  - With SEG_ACTIVE_LOW=1, each seg is the bitwise inverse (e.g. digit 8 -> 00).
- Start playback of 3 digits; pulse clear during the 2nd SHOW.
  - Next clock: seg blank, busy=0, full=0.
  - A run edge then produces no playback (count=0).
- Assert reset mid-GAP.
  - Outputs blank and busy=0 immediately, without waiting for a clock edge.
  - Writes after reset are stored from slot 0.
- With SEG7_SEQ_LOOP_EN, digits 7,A, run held high.
  - Expect 07,blank,77(dp),blank,07,... repeating.
  - Drop run: return to IDLE at the end of the current period.
